// File: rtl/multiply_if.sv
// rtl/multiply_if.sv - operand/result stream bundle for the multiply stage
interface multiply_if #(
    parameter int ARGW = 16,
    parameter int RESW = 32
);
    logic                   arg0_stb;
    logic signed [ARGW-1:0] arg0_dat;
    logic                   arg0_rdy;
    logic                   arg1_stb;
    logic signed [ARGW-1:0] arg1_dat;
    logic                   arg1_rdy;
    logic                   res_stb;
    logic        [RESW-1:0] res_dat;
    logic                   res_rdy;

    // Producer of operands and consumer of results
    modport master (
        output arg0_stb, arg0_dat, input arg0_rdy,
        output arg1_stb, arg1_dat, input arg1_rdy,
        input  res_stb,  res_dat,  output res_rdy
    );

    // The multiply stage itself
    modport slave (
        input  arg0_stb, arg0_dat, output arg0_rdy,
        input  arg1_stb, arg1_dat, output arg1_rdy,
        output res_stb,  res_dat,  input  res_rdy
    );
endinterface

// File: rtl/multiply.sv
// rtl/multiply.sv - two-stage signed fixed-point multiply, joined operand streams; MULTIPLY_ROUND_EN selects round-half-up
module multiply #(
    parameter int ARGW = 16,
    parameter int RESW = 32,
    parameter int FRAC = 0
) (
    input  logic       clk,
    input  logic       rst,
    multiply_if.slave  io_bus
);
    // Full product width plus one guard bit so the rounding add cannot wrap
    localparam int PW = 2 * ARGW + 1;

    logic                   r_s1_vld;
    logic signed [ARGW-1:0] r_s1_a;
    logic signed [ARGW-1:0] r_s1_b;
    logic                   r_res_stb;
    logic        [RESW-1:0] r_res_dat;

    logic                   w_s2_adv;
    logic                   w_s1_acc;
    logic                   w_xfer;
    logic signed [PW-1:0]   w_a_ext;
    logic signed [PW-1:0]   w_b_ext;
    logic signed [PW-1:0]   w_prod;
    logic signed [PW-1:0]   w_sum;
    logic signed [PW-1:0]   w_shf;
    logic        [RESW-1:0] w_res;

    // Handshake: stage 2 moves when its output is empty or being taken,
    // stage 1 accepts when empty or draining into stage 2.
    assign w_s2_adv = ~r_res_stb | io_bus.res_rdy;
    assign w_s1_acc = ~r_s1_vld | w_s2_adv;

    // Join: each side is ready only when the other side is offering, so
    // both operands move together or not at all.
    assign io_bus.arg0_rdy = ~rst & w_s1_acc & io_bus.arg1_stb;
    assign io_bus.arg1_rdy = ~rst & w_s1_acc & io_bus.arg0_stb;
    assign w_xfer          = ~rst & w_s1_acc & io_bus.arg0_stb & io_bus.arg1_stb;

    // Product at full width from the stage-1 operands
    assign w_a_ext = PW'(r_s1_a);
    assign w_b_ext = PW'(r_s1_b);
    assign w_prod  = w_a_ext * w_b_ext;

`ifdef MULTIPLY_ROUND_EN
    localparam int            RSH = (FRAC > 0) ? FRAC - 1 : 0;
    localparam logic [PW-1:0] RND = (FRAC > 0) ? (PW'(1) << RSH) : '0;
    assign w_sum = w_prod + RND;
`else
    assign w_sum = w_prod;
`endif

    // Drop fractional bits, then fit to the result width (sign-extend or
    // discard redundant sign bits; the value always fits in RESW).
    assign w_shf = w_sum >>> FRAC;
    assign w_res = RESW'(w_shf);

    assign io_bus.res_stb = r_res_stb;
    assign io_bus.res_dat = r_res_dat;

    // Stage 1: capture an operand pair on joint transfer, empty when drained
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_vld <= 1'b0;
            r_s1_a   <= '0;
            r_s1_b   <= '0;
        end else if (w_xfer) begin
            r_s1_vld <= 1'b1;
            r_s1_a   <= io_bus.arg0_dat;
            r_s1_b   <= io_bus.arg1_dat;
        end else if (w_s2_adv) begin
            r_s1_vld <= 1'b0;
        end
    end

    // Stage 2: register the scaled product; hold steady while stalled
    always_ff @(posedge clk) begin
        if (rst) begin
            r_res_stb <= 1'b0;
            r_res_dat <= '0;
        end else if (w_s2_adv) begin
            r_res_stb <= r_s1_vld;
            r_res_dat <= w_res;
        end
    end
endmodule

// File: tb/tb_multiply.sv
// tb/tb_multiply.sv - bench for multiply with FRAC=0 and FRAC=8 instances
module tb_multiply;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    multiply_if #(.ARGW(16), .RESW(32)) b0 ();
    multiply_if #(.ARGW(16), .RESW(32)) b8 ();

    multiply #(.ARGW(16), .RESW(32), .FRAC(0)) u0 (.clk(clk), .rst(rst), .io_bus(b0));
    multiply #(.ARGW(16), .RESW(32), .FRAC(8)) u8 (.clk(clk), .rst(rst), .io_bus(b8));

    logic signed [63:0] q0[$];
    logic signed [63:0] q8[$];

    // Reference: exact product, optional half-up bias, then floor division by 2^frac
    function automatic logic signed [63:0] ref_mul(input logic signed [15:0] a,
                                                   input logic signed [15:0] b,
                                                   input int frac);
        longint p;
        p = longint'(a) * longint'(b);
`ifdef MULTIPLY_ROUND_EN
        if (frac > 0) p = p + (longint'(1) <<< (frac - 1));
`endif
        return p >>> frac;
    endfunction

    task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard for the FRAC=0 instance
    always @(negedge clk) begin
        if (rst) begin
            q0.delete();
        end else begin
            chk("m0_join", {63'd0, b0.arg0_stb & b0.arg0_rdy}, {63'd0, b0.arg1_stb & b0.arg1_rdy});
            if (b0.res_stb && b0.res_rdy) begin
                chk("m0_expected", {63'd0, q0.size() > 0}, 64'sd1);
                if (q0.size() > 0) chk("m0_res", $signed(b0.res_dat), q0.pop_front());
            end
            if (b0.arg0_stb && b0.arg0_rdy && b0.arg1_stb)
                q0.push_back(ref_mul(b0.arg0_dat, b0.arg1_dat, 0));
        end
    end

    // Scoreboard for the FRAC=8 instance
    always @(negedge clk) begin
        if (rst) begin
            q8.delete();
        end else begin
            if (b8.res_stb && b8.res_rdy) begin
                chk("m8_expected", {63'd0, q8.size() > 0}, 64'sd1);
                if (q8.size() > 0) chk("m8_res", $signed(b8.res_dat), q8.pop_front());
            end
            if (b8.arg0_stb && b8.arg0_rdy && b8.arg1_stb)
                q8.push_back(ref_mul(b8.arg0_dat, b8.arg1_dat, 8));
        end
    end

    logic signed [15:0] pa[4];
    logic signed [15:0] pb[4];
    logic signed [15:0] xa[3];
    logic signed [15:0] xb[3];
    logic signed [63:0] xe[3];
    logic signed [63:0] x8e[3];
    logic signed [63:0] hold_val;
    int acc;
    int j;

    initial begin
        // ---- 1: reset and first-transaction latency ----
        b0.arg0_stb = 1'b1; b0.arg0_dat = 16'sd3;
        b0.arg1_stb = 1'b1; b0.arg1_dat = -16'sd4;
        b0.res_rdy  = 1'b1;
        b8.arg0_stb = 1'b0; b8.arg0_dat = '0;
        b8.arg1_stb = 1'b0; b8.arg1_dat = '0;
        b8.res_rdy  = 1'b1;
        rst = 1'b1;
        tick();
        tick();
        chk("rst_arg0_rdy", {63'd0, b0.arg0_rdy}, 64'sd0);
        chk("rst_arg1_rdy", {63'd0, b0.arg1_rdy}, 64'sd0);
        chk("rst_res_stb", {63'd0, b0.res_stb}, 64'sd0);
        chk("rst_res_dat", $signed(b0.res_dat), 64'sd0);
        rst = 1'b0;
        #1;
        chk("t1_xfer_rdy", {63'd0, b0.arg0_rdy & b0.arg1_rdy}, 64'sd1);
        tick();
        b0.arg0_stb = 1'b0; b0.arg1_stb = 1'b0;
        #1;
        chk("t1_n1_stb", {63'd0, b0.res_stb}, 64'sd0);
        tick();
        chk("t1_n2_stb", {63'd0, b0.res_stb}, 64'sd1);
        chk("t1_n2_dat", $signed(b0.res_dat), -64'sd12);
        tick();

        // ---- 2: lone stb is held with no transfer ----
        b0.arg0_stb = 1'b1; b0.arg0_dat = 16'sd5;
        for (int c = 0; c < 6; c++) begin
            #1;
            chk("t2_lone_rdy", {63'd0, b0.arg0_rdy}, 64'sd0);
            chk("t2_lone_res", {63'd0, b0.res_stb}, 64'sd0);
            tick();
        end
        b0.arg1_stb = 1'b1; b0.arg1_dat = 16'sd7;
        #1;
        chk("t2_join_rdy", {63'd0, b0.arg0_rdy & b0.arg1_rdy}, 64'sd1);
        tick();
        b0.arg0_stb = 1'b0; b0.arg1_stb = 1'b0;
        tick();
        chk("t2_res_stb", {63'd0, b0.res_stb}, 64'sd1);
        chk("t2_res_dat", $signed(b0.res_dat), 64'sd35);
        tick();

        // ---- 3: back-to-back pairs at full throughput ----
        for (int i = 0; i < 10; i++) begin
            if (i < 8) begin
                b0.arg0_stb = 1'b1; b0.arg0_dat = 16'(i);
                b0.arg1_stb = 1'b1; b0.arg1_dat = 16'(i + 1);
            end else begin
                b0.arg0_stb = 1'b0; b0.arg1_stb = 1'b0;
            end
            #1;
            if (i < 8) chk("t3_rdy", {63'd0, b0.arg0_rdy}, 64'sd1);
            if (i >= 2) begin
                chk("t3_stb", {63'd0, b0.res_stb}, 64'sd1);
                chk("t3_dat", $signed(b0.res_dat), 64'((i - 2) * (i - 1)));
            end
            tick();
        end
        chk("t3_done", {63'd0, b0.res_stb}, 64'sd0);

        // ---- 4: backpressure, in-flight limit, drain, mid-stream reset ----
        for (int k = 0; k < 4; k++) begin
            pa[k] = 16'(100 + k);
            pb[k] = 16'(-(k + 1));
        end
        b0.res_rdy = 1'b0;
        acc = 0; j = 0;
        b0.arg0_stb = 1'b1; b0.arg1_stb = 1'b1;
        b0.arg0_dat = pa[0]; b0.arg1_dat = pb[0];
        for (int c = 0; c < 4; c++) begin
            #1;
            if (b0.arg0_rdy) begin
                acc++;
                j++;
            end
            tick();
            b0.arg0_dat = pa[j]; b0.arg1_dat = pb[j];
        end
        chk("t4_accepted", 64'(acc), 64'sd2);
        hold_val = ref_mul(pa[0], pb[0], 0);
        for (int c = 0; c < 10; c++) begin
            #1;
            chk("t4_hold_stb", {63'd0, b0.res_stb}, 64'sd1);
            chk("t4_hold_dat", $signed(b0.res_dat), hold_val);
            chk("t4_full_rdy", {63'd0, b0.arg0_rdy | b0.arg1_rdy}, 64'sd0);
            tick();
        end
        b0.res_rdy = 1'b1;
        for (int c = 0; c < 4; c++) begin
            #1;
            chk("t4_drain_stb", {63'd0, b0.res_stb}, 64'sd1);
            chk("t4_drain_dat", $signed(b0.res_dat), ref_mul(pa[c], pb[c], 0));
            if (b0.arg0_stb && b0.arg0_rdy) j++;
            tick();
            if (j < 4) begin
                b0.arg0_dat = pa[j]; b0.arg1_dat = pb[j];
            end else begin
                b0.arg0_stb = 1'b0; b0.arg1_stb = 1'b0;
            end
        end
        #1;
        chk("t4_drained", {63'd0, b0.res_stb}, 64'sd0);
        chk("t4_all_taken", 64'(j), 64'sd4);
        tick();
        b0.res_rdy = 1'b0;
        b0.arg0_stb = 1'b1; b0.arg0_dat = 16'sd7;
        b0.arg1_stb = 1'b1; b0.arg1_dat = 16'sd7;
        tick();
        b0.arg0_dat = 16'sd8; b0.arg1_dat = 16'sd8;
        tick();
        b0.arg0_stb = 1'b0; b0.arg1_stb = 1'b0;
        rst = 1'b1;
        #1;
        chk("t4_pre_rst_stb", {63'd0, b0.res_stb}, 64'sd1);
        tick();
        rst = 1'b0;
        b0.res_rdy = 1'b1;
        chk("t4_rst_stb", {63'd0, b0.res_stb}, 64'sd0);
        for (int c = 0; c < 4; c++) begin
            tick();
            chk("t4_flushed", {63'd0, b0.res_stb}, 64'sd0);
        end

        // ---- 5: extreme products, FRAC=0 ----
        xa[0] = -16'sd32768; xb[0] = -16'sd32768; xe[0] = 64'sd1073741824;
        xa[1] = -16'sd32768; xb[1] = 16'sd32767;  xe[1] = -64'sd1073709056;
        xa[2] = 16'sd32767;  xb[2] = 16'sd32767;  xe[2] = 64'sd1073676289;
        for (int i = 0; i < 5; i++) begin
            if (i < 3) begin
                b0.arg0_stb = 1'b1; b0.arg0_dat = xa[i];
                b0.arg1_stb = 1'b1; b0.arg1_dat = xb[i];
            end else begin
                b0.arg0_stb = 1'b0; b0.arg1_stb = 1'b0;
            end
            #1;
            if (i >= 2) begin
                chk("t5_stb", {63'd0, b0.res_stb}, 64'sd1);
                chk("t5_dat", $signed(b0.res_dat), xe[i - 2]);
            end
            tick();
        end

        // ---- 6: FRAC=8 rounding behaviour ----
        xa[0] = 16'sd1;   xb[0] = 16'sd128;
        xa[1] = -16'sd1;  xb[1] = 16'sd128;
        xa[2] = 16'sd384; xb[2] = 16'sd256;
`ifdef MULTIPLY_ROUND_EN
        x8e[0] = 64'sd1;  x8e[1] = 64'sd0;
`else
        x8e[0] = 64'sd0;  x8e[1] = -64'sd1;
`endif
        x8e[2] = 64'sd384;
        for (int i = 0; i < 5; i++) begin
            if (i < 3) begin
                b8.arg0_stb = 1'b1; b8.arg0_dat = xa[i];
                b8.arg1_stb = 1'b1; b8.arg1_dat = xb[i];
            end else begin
                b8.arg0_stb = 1'b0; b8.arg1_stb = 1'b0;
            end
            #1;
            if (i >= 2) begin
                chk("t6_stb", {63'd0, b8.res_stb}, 64'sd1);
                chk("t6_dat", $signed(b8.res_dat), x8e[i - 2]);
            end
            tick();
        end

        // ---- 7: random traffic on both instances against the reference ----
        for (int c = 0; c < 400; c++) begin
            b0.arg0_stb = ($urandom_range(0, 9) < 7);
            b0.arg1_stb = ($urandom_range(0, 9) < 7);
            b0.arg0_dat = 16'($urandom);
            b0.arg1_dat = 16'($urandom);
            b0.res_rdy  = ($urandom_range(0, 9) < 6);
            b8.arg0_stb = ($urandom_range(0, 9) < 7);
            b8.arg1_stb = ($urandom_range(0, 9) < 7);
            b8.arg0_dat = 16'($urandom);
            b8.arg1_dat = 16'($urandom);
            b8.res_rdy  = ($urandom_range(0, 9) < 6);
            tick();
        end
        b0.arg0_stb = 1'b0; b0.arg1_stb = 1'b0; b0.res_rdy = 1'b1;
        b8.arg0_stb = 1'b0; b8.arg1_stb = 1'b0; b8.res_rdy = 1'b1;
        for (int c = 0; c < 6; c++) tick();
        chk("t7_q0_empty", 64'(q0.size()), 64'sd0);
        chk("t7_q8_empty", 64'(q8.size()), 64'sd0);
        chk("t7_idle0", {63'd0, b0.res_stb}, 64'sd0);
        chk("t7_idle8", {63'd0, b8.res_stb}, 64'sd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
